// File: rtl/bignum_addsub_unit.sv
`default_nettype none
// =============================================================================
// Module      : bignum_addsub_unit
// Description : Multi-word add/subtract over a shared SRAM port, LS word first,
//               with top-word masking and carry/borrow reporting.
// Revision    : 2.0 - subtract mode, read latency, masking, busy, carry out
// =============================================================================
module bignum_addsub_unit #(
  parameter int ADRBW  = 20,
  parameter int WRDBW  = 16,
  parameter int VARBW  = 17,
  parameter int RD_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_sub,
  input  logic [VARBW-1:0] i_varsize,
  input  logic [ADRBW-1:0] i_aaddr,
  input  logic [ADRBW-1:0] i_baddr,
  input  logic [ADRBW-1:0] i_raddr,
  input  logic [WRDBW-1:0] i_rdata,
  output logic             o_wen,
  output logic [ADRBW-1:0] o_addr,
  output logic [WRDBW-1:0] o_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry
);

  localparam int               c_rbw      = $clog2(WRDBW + 1);
  localparam logic [VARBW-1:0] c_wrdbw_v  = VARBW'(WRDBW);
  localparam logic [VARBW-1:0] c_one_v    = VARBW'(1);
  localparam logic             c_lat_last = (RD_LAT != 0);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_rd_a = 3'd1;
  localparam logic [2:0] c_st_rd_b = 3'd2;
  localparam logic [2:0] c_st_wr   = 3'd3;
  localparam logic [2:0] c_st_fin  = 3'd4;

  logic [2:0]       r_state;
  logic             r_sub;
  logic [ADRBW-1:0] r_aaddr;
  logic [ADRBW-1:0] r_baddr;
  logic [ADRBW-1:0] r_raddr;
  logic [VARBW-1:0] r_last;
  logic [VARBW-1:0] r_idx;
  logic [c_rbw-1:0] r_rem;
  logic             r_lat;
  logic             r_carry;
  logic             r_cout;
  logic [WRDBW-1:0] r_a;
  logic [WRDBW-1:0] r_b;

  logic             w_top;
  logic [WRDBW-1:0] w_mask;
  logic [WRDBW-1:0] w_opa;
  logic [WRDBW-1:0] w_opb;
  logic [WRDBW:0]   w_sum;
  logic             w_cnext;
  logic [ADRBW-1:0] w_off;
  logic             w_lat_done;
  logic [VARBW-1:0] w_last_in;
  logic [c_rbw-1:0] w_rem_in;

  assign w_last_in  = (i_varsize - c_one_v) / c_wrdbw_v;
  assign w_rem_in   = c_rbw'(i_varsize % c_wrdbw_v);
  assign w_off      = ADRBW'(r_idx);
  assign w_lat_done = (r_lat == c_lat_last);

  // B is inverted before masking so the bits above the operand size stay zero
  // and the borrow lands on sum bit r_rem.
  assign w_top   = (r_idx == r_last) && (r_rem != '0);
  assign w_mask  = w_top ? ~({WRDBW{1'b1}} << r_rem) : {WRDBW{1'b1}};
  assign w_opa   = r_a & w_mask;
  assign w_opb   = (r_sub ? ~r_b : r_b) & w_mask;
  assign w_sum   = {1'b0, w_opa} + {1'b0, w_opb} + {{WRDBW{1'b0}}, r_carry};
  assign w_cnext = w_top ? w_sum[r_rem] : w_sum[WRDBW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_sub   <= 1'b0;
      r_aaddr <= '0;
      r_baddr <= '0;
      r_raddr <= '0;
      r_last  <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_lat   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (i_valid) begin
            r_cout <= 1'b0;
            if (i_varsize == '0) begin
              r_state <= c_st_fin;
            end else begin
              r_sub   <= i_sub;
              r_aaddr <= i_aaddr;
              r_baddr <= i_baddr;
              r_raddr <= i_raddr;
              r_last  <= w_last_in;
              r_rem   <= w_rem_in;
              r_idx   <= '0;
              r_lat   <= 1'b0;
              r_carry <= i_sub;
              r_state <= c_st_rd_a;
            end
          end
        end
        c_st_rd_a: begin
          if (w_lat_done) begin
            r_a     <= i_rdata;
            r_lat   <= 1'b0;
            r_state <= c_st_rd_b;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        c_st_rd_b: begin
          if (w_lat_done) begin
            r_b     <= i_rdata;
            r_lat   <= 1'b0;
            r_state <= c_st_wr;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        c_st_wr: begin
          r_carry <= w_cnext;
          if (r_idx == r_last) begin
            // Subtract reports borrow, the inverse of the final carry.
            r_cout  <= w_cnext ^ r_sub;
            r_state <= c_st_fin;
          end else begin
            r_idx   <= r_idx + c_one_v;
            r_state <= c_st_rd_a;
          end
        end
        c_st_fin: r_state <= c_st_idle;
        default:  r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    o_wen   = 1'b0;
    o_addr  = '0;
    o_wdata = '0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      c_st_rd_a: begin
        o_addr = r_aaddr + w_off;
        o_busy = 1'b1;
      end
      c_st_rd_b: begin
        o_addr = r_baddr + w_off;
        o_busy = 1'b1;
      end
      c_st_wr: begin
        o_wen   = 1'b1;
        o_addr  = r_raddr + w_off;
        o_wdata = w_sum[WRDBW-1:0] & w_mask;
        o_busy  = 1'b1;
      end
      c_st_fin: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_carry = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bignum_addsub_unit.sv
`default_nettype none
// =============================================================================
// Module      : tb_bignum_addsub_unit
// Description : Directed self-checking bench; one instance per read latency.
// Revision    : 2.0 - initial bench for the add/subtract unit
// =============================================================================
module tb_bignum_addsub_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic        i_sub = 1'b0;
  logic [16:0] i_varsize = '0;
  logic [19:0] i_aaddr = '0;
  logic [19:0] i_baddr = '0;
  logic [19:0] i_raddr = '0;

  logic [15:0] rdata0, rdata1;
  logic        wen0, wen1, busy0, busy1, done0, done1, carry0, carry1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic [15:0] mem0 [0:63];
  logic [15:0] mem1 [0:63];
  logic        ld_en = 1'b0;
  logic        ld_sel = 1'b0;
  logic [5:0]  ld_a = '0;
  logic [15:0] ld_d = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bignum_addsub_unit #(.ADRBW(20), .WRDBW(16), .VARBW(17), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid0), .i_sub(i_sub), .i_varsize(i_varsize),
    .i_aaddr(i_aaddr), .i_baddr(i_baddr), .i_raddr(i_raddr), .i_rdata(rdata0),
    .o_wen(wen0), .o_addr(addr0), .o_wdata(wdata0), .o_busy(busy0),
    .o_done(done0), .o_carry(carry0)
  );

  bignum_addsub_unit #(.ADRBW(20), .WRDBW(16), .VARBW(17), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid1), .i_sub(i_sub), .i_varsize(i_varsize),
    .i_aaddr(i_aaddr), .i_baddr(i_baddr), .i_raddr(i_raddr), .i_rdata(rdata1),
    .o_wen(wen1), .o_addr(addr1), .o_wdata(wdata1), .o_busy(busy1),
    .o_done(done1), .o_carry(carry1)
  );

  // SRAM models: combinational read for dut0, registered read for dut1.
  assign rdata0 = mem0[addr0[5:0]];
  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem0[ld_a] <= ld_d;
    if (ld_en && ld_sel)  mem1[ld_a] <= ld_d;
    if (wen0) mem0[addr0[5:0]] <= wdata0;
    if (wen1) mem1[addr1[5:0]] <= wdata1;
    rdata1 <= mem1[addr1[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ld(input bit sel, input int a, input logic [15:0] d);
    @(negedge clk);
    ld_sel = sel; ld_a = 6'(a); ld_d = d; ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic run(input bit sel, input bit sub, input int vs, input int aa,
                     input int ba, input int ra, input bit glitch,
                     output int lat, output int nwen, output int hold0, output bit busy_ok);
    bit dn;
    logic w, b, d;
    logic [19:0] ad;
    @(negedge clk);
    i_sub = sub; i_varsize = 17'(vs);
    i_aaddr = 20'(aa); i_baddr = 20'(ba); i_raddr = 20'(ra);
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    #1 valid0 = 1'b0; valid1 = 1'b0;
    lat = 0; nwen = 0; hold0 = 0; busy_ok = 1'b1; dn = 1'b0;
    while (!dn && lat < 200) begin
      @(negedge clk);
      lat++;
      w  = sel ? wen1  : wen0;
      b  = sel ? busy1 : busy0;
      d  = sel ? done1 : done0;
      ad = sel ? addr1 : addr0;
      if (w) nwen++;
      if (b && ad == 20'(aa)) hold0++;
      if (d) begin
        dn = 1'b1;
        if (b) busy_ok = 1'b0;
      end else if (!b) begin
        busy_ok = 1'b0;
      end
      if (glitch && lat == 2) begin
        i_varsize = '0; i_sub = ~sub;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
      end
      if (glitch && lat == 3) begin
        valid0 = 1'b0; valid1 = 1'b0;
      end
    end
    if (!dn) lat = -1;
  endtask

  initial begin
    int lat, nwen, hold0, k;
    bit busy_ok;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl0", 32'({wen0, busy0, done0, carry0}), 32'h0);
    check("reset_bus0", 32'(addr0) | 32'(wdata0), 32'h0);
    check("reset_ctl1", 32'({wen1, busy1, done1, carry1}), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    ld(0, 0, 16'h475a); ld(0, 1, 16'h9844);
    ld(0, 5, 16'h0457); ld(0, 6, 16'h000f);
    ld(0, 20, 16'hffff); ld(0, 21, 16'hffff);
    ld(0, 22, 16'h0001); ld(0, 23, 16'h0000);
    ld(0, 30, 16'hffff); ld(0, 31, 16'hfe0f);
    ld(0, 32, 16'h0001); ld(0, 33, 16'hab00);
    ld(0, 40, 16'h0001); ld(0, 41, 16'h0000);
    ld(0, 42, 16'h0002); ld(0, 43, 16'h0000);
    ld(1, 0, 16'h1234); ld(1, 1, 16'hffff); ld(1, 2, 16'h0001);
    ld(1, 3, 16'hedcc); ld(1, 4, 16'h0001); ld(1, 5, 16'h0002);

    run(0, 0, 32, 0, 5, 10, 0, lat, nwen, hold0, busy_ok);
    check("add_w0", 32'(mem0[10]), 32'h4bb1);
    check("add_w1", 32'(mem0[11]), 32'h9853);
    check("add_carry", 32'(carry0), 32'h0);
    check("add_latency", 32'(lat), 32'd7);
    check("add_busy", 32'(busy_ok), 32'h1);
    check("add_nwen", 32'(nwen), 32'd2);

    run(0, 1, 32, 0, 5, 12, 0, lat, nwen, hold0, busy_ok);
    check("sub_w0", 32'(mem0[12]), 32'h4303);
    check("sub_w1", 32'(mem0[13]), 32'h9835);
    check("sub_borrow", 32'(carry0), 32'h0);

    run(0, 1, 32, 5, 0, 14, 0, lat, nwen, hold0, busy_ok);
    check("subswap_w0", 32'(mem0[14]), 32'hbcfd);
    check("subswap_w1", 32'(mem0[15]), 32'h67ca);
    check("subswap_borrow", 32'(carry0), 32'h1);

    run(0, 0, 32, 20, 22, 24, 0, lat, nwen, hold0, busy_ok);
    check("ripple_w0", 32'(mem0[24]), 32'h0000);
    check("ripple_w1", 32'(mem0[25]), 32'h0000);
    check("ripple_carry", 32'(carry0), 32'h1);

    run(0, 0, 20, 30, 32, 34, 0, lat, nwen, hold0, busy_ok);
    check("mask_add_w0", 32'(mem0[34]), 32'h0000);
    check("mask_add_w1", 32'(mem0[35]), 32'h0000);
    check("mask_add_carry", 32'(carry0), 32'h1);
    check("mask_add_latency", 32'(lat), 32'd7);

    run(0, 1, 20, 40, 42, 44, 0, lat, nwen, hold0, busy_ok);
    check("mask_sub_w0", 32'(mem0[44]), 32'hffff);
    check("mask_sub_w1", 32'(mem0[45]), 32'h000f);
    check("mask_sub_borrow", 32'(carry0), 32'h1);

    run(0, 0, 0, 0, 5, 10, 0, lat, nwen, hold0, busy_ok);
    check("zero_latency", 32'(lat), 32'd1);
    check("zero_nwen", 32'(nwen), 32'd0);
    check("zero_carry", 32'(carry0), 32'h0);

    run(1, 0, 48, 0, 3, 6, 0, lat, nwen, hold0, busy_ok);
    check("lat1_w0", 32'(mem1[6]), 32'h0000);
    check("lat1_w1", 32'(mem1[7]), 32'h0001);
    check("lat1_w2", 32'(mem1[8]), 32'h0004);
    check("lat1_carry", 32'(carry1), 32'h0);
    check("lat1_latency", 32'(lat), 32'd16);
    check("lat1_addr_hold", 32'(hold0), 32'd2);

    run(0, 0, 32, 0, 5, 46, 1, lat, nwen, hold0, busy_ok);
    check("glitch_latency", 32'(lat), 32'd7);
    check("glitch_w0", 32'(mem0[46]), 32'h4bb1);
    check("glitch_w1", 32'(mem0[47]), 32'h9853);
    @(negedge clk);
    check("glitch_no_restart", 32'({busy0, done0}), 32'h0);

    @(negedge clk);
    i_sub = 1'b0; i_varsize = 17'd32;
    i_aaddr = 20'd0; i_baddr = 20'd5; i_raddr = 20'd50;
    valid0 = 1'b1;
    @(posedge clk);
    #1 valid0 = 1'b0;
    k = 0;
    while (!wen0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_reached_wr", 32'(wen0), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_ctl", 32'({wen0, busy0, done0, carry0}), 32'h0);
    check("rst_bus", 32'(addr0) | 32'(wdata0), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done0) seen = 1'b1;
    check("rst_no_done", 32'(seen), 32'h0);

    run(0, 0, 32, 0, 5, 50, 0, lat, nwen, hold0, busy_ok);
    check("post_rst_w0", 32'(mem0[50]), 32'h4bb1);
    check("post_rst_w1", 32'(mem0[51]), 32'h9853);
    check("post_rst_latency", 32'(lat), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
